pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Program-counter register and redirect controller for the 5-stage RISC-V core.
- Sits downstream of the branch condition unit.
- Consumes the EX-stage taken decision plus jump flags, selects the next PC (sequential, stall-hold or redirect target), and drives the pipeline flush that kills wrong-path instructions.
- Flags misaligned control-transfer targets for the trap logic.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, number of flush cycles after a redirect (range 1..3).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard-unit stall; PC holds when set.
- ex_valid_i  input  1  EX-stage instruction is valid.
- ex_is_branch_i  input  1  EX instruction is a conditional branch.
- ex_is_jal_i  input  1  EX instruction is JAL.
- ex_is_jalr_i  input  1  EX instruction is JALR.
- branch_taken_i  input  1  taken output of the branch condition unit.
- ex_target_i  input  XLEN  computed target (branch/JAL: pc+imm; JALR: rs1+imm).
- pc_o  output  XLEN  current fetch PC.
- pc_plus4_o  output  XLEN  pc_o+4, combinational, wraps modulo 2^XLEN.
- flush_o  output  1  kill IF/ID and ID/EX contents.
- redirect_o  output  1  one-cycle pulse: redirect accepted this cycle.
- misalign_o  output  1  one-cycle pulse: target misaligned, redirect suppressed.

Behaviour:
- Reset is asynchronous and active-low.
  - pc_o=RESET_PC; flush_o=0, redirect_o=0, misalign_o=0; state=RUN; flush counter=0.
  - Reset asserted mid-flush aborts the flush immediately.
- Effective target:
  - eff_tgt = ex_target_i with bit0 forced to 0 when ex_is_jalr_i=1; otherwise ex_target_i unchanged.
- Redirect request: req = ex_valid_i & (ex_is_branch_i&branch_taken_i | ex_is_jal_i | ex_is_jalr_i).
  - If more than one type flag is set, the request is still one redirect to eff_tgt.
- Misalignment: mis = req & eff_tgt[1].
  - No compressed support, so eff_tgt[1] set is a fault.
- Redirect priority: redirect beats stall.
- State RUN:
  - req & !mis at edge N:
    - pc_o=eff_tgt after edge N.
    - redirect_o high for the cycle after edge N.
    - state→FLUSH, counter=FLUSH_DEPTH-1.
  - req & mis:
    - misalign_o high for one cycle after the edge; no redirect.
    - PC follows the normal stall/advance rule.
    - Trap redirect is handled elsewhere.
  - No req: stall_i ? hold : pc_o+4.
- State FLUSH:
  - flush_o=1 for the whole state; it is a registered output.
  - req, mis and ex_valid_i are ignored, because EX holds wrong-path instructions.
  - pc_o advances by 4 unless stall_i.
  - Counter decrements only when !stall_i.
  - Counter==0 & !stall_i → RUN.
  - Net effect: flush_o is high for exactly FLUSH_DEPTH non-stalled cycles.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 → 0.
- flush_o is never set in RUN.
- redirect_o and misalign_o are never high in the same cycle.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - Adds outputs branch_cnt_o[31:0] and taken_cnt_o[31:0].
  - branch_cnt_o counts accepted ex_valid_i&ex_is_branch_i in RUN.
  - taken_cnt_o counts those with branch_taken_i=1.
  - Both counters wrap, reset to 0, and do not count in FLUSH.
- Undefined: the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Shared package:
  - state encodings RUN=1'b0, FLUSH=1'b1;
  - PC_STEP=4;
  - RESET_PC default;
  - alignment-check mask.
- Sub-module pc_flush_ctr: loadable down-counter with stall-freeze, load, zero flag. It is the only natural split; everything else stays in the top.

Test Plan:
- Reset release, no stall, no req, 4 cycles → pc_o 0,4,8,12; flush_o=0.
- pc_o=0x20, taken beq with ex_target_i=0x100 → next pc_o=0x100, redirect_o 1 cycle, flush_o 2 cycles, then pc_o 0x104,0x108 and RUN.
- JALR with ex_target_i=0x201 while stall_i=1 → pc_o=0x200 (redirect beats stall); second req during FLUSH ignored.
- JAL with ex_target_i=0x102 → misalign_o pulse, no redirect; pc_o=prev+4, flush_o=0.
- Redirect, then stall_i high 3 cycles inside FLUSH → flush_o stays high, pc_o holds, flush ends after 2 non-stalled cycles; rst_n low mid-flush → pc_o=RESET_PC, flush_o=0 immediately.
- BRANCH_PERF_CNT_EN: 3 branches (2 taken, 1 not) in RUN → branch_cnt_o=3, taken_cnt_o=2.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the PC register / redirect controller.
package pc_redirect_unit_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          CTR_W            = 2;

    // Without compressed instructions, bit 1 of a control-transfer target must be clear.
    localparam logic [1:0]  ALIGN_MASK       = 2'b10;

endpackage

// File: rtl/pc_flush_ctr.sv
// Loadable down-counter for the flush window: load wins, decrement only while enabled, zero flag.
module pc_flush_ctr
    import pc_redirect_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register and redirect/flush controller. Optional branch performance
// counters are built when BRANCH_PERF_CNT_EN is defined.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
    parameter int              FLUSH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_is_jal_i,
    input  logic            ex_is_jalr_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic            misalign_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     taken_cnt_o
`endif
);

    state_t          state;
    logic [XLEN-1:0] eff_tgt;
    logic            req;
    logic            mis;
    logic            ctr_load;
    logic            ctr_en;
    logic            ctr_zero;

    always_comb begin
        eff_tgt = ex_target_i;
        if (ex_is_jalr_i) begin
            eff_tgt[0] = 1'b0;
        end
    end

    assign req = ex_valid_i & ((ex_is_branch_i & branch_taken_i) | ex_is_jal_i | ex_is_jalr_i);
    assign mis = req & (|(eff_tgt[1:0] & ALIGN_MASK));

    assign pc_plus4_o = pc_o + XLEN'(PC_STEP);

    assign ctr_load = (state == RUN) & req & ~mis;
    assign ctr_en   = (state == FLUSH) & ~stall_i;

    pc_flush_ctr u_flush_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (CTR_W'(FLUSH_DEPTH - 1)),
        .en       (ctr_en),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc_o       <= RESET_PC;
            flush_o    <= 1'b0;
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                RUN: begin
                    // A redirect overrides a stall: the target must be fetched.
                    if (req && !mis) begin
                        pc_o       <= eff_tgt;
                        redirect_o <= 1'b1;
                        flush_o    <= 1'b1;
                        state      <= FLUSH;
                    end else begin
                        misalign_o <= mis;
                        if (!stall_i) begin
                            pc_o <= pc_plus4_o;
                        end
                    end
                end
                FLUSH: begin
                    // EX holds wrong-path instructions here, so its request is ignored.
                    if (!stall_i) begin
                        pc_o <= pc_plus4_o;
                        if (ctr_zero) begin
                            flush_o <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_o <= '0;
            taken_cnt_o  <= '0;
        end else if ((state == RUN) && ex_valid_i && ex_is_branch_i) begin
            branch_cnt_o <= branch_cnt_o + 32'd1;
            if (branch_taken_i) begin
                taken_cnt_o <= taken_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized
// traffic against a behavioural model (BRANCH_PERF_CNT_EN adds counter checks).
module tb_pc_redirect_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, ex_valid_i = 1'b0, ex_is_branch_i = 1'b0;
    logic        ex_is_jal_i = 1'b0, ex_is_jalr_i = 1'b0, branch_taken_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic [31:0] pc_o, pc_plus4_o;
    logic        flush_o, redirect_o, misalign_o;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_o, taken_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: fetch PC, remaining non-stalled flush cycles, last-cycle pulses.
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_redirect, m_mis;
    logic [31:0] m_br, m_tk;

    pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .ex_valid_i     (ex_valid_i),
        .ex_is_branch_i (ex_is_branch_i),
        .ex_is_jal_i    (ex_is_jal_i),
        .ex_is_jalr_i   (ex_is_jalr_i),
        .branch_taken_i (branch_taken_i),
        .ex_target_i    (ex_target_i),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .misalign_o     (misalign_o)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_cnt_o   (branch_cnt_o),
        .taken_cnt_o    (taken_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 32'h0; m_flush_left = 0; m_redirect = 1'b0; m_mis = 1'b0;
        m_br = '0; m_tk = '0;
    endtask

    // Drive one cycle of inputs, advance across a rising edge, update the model,
    // and return 1 time unit after the edge so outputs are sampled off-edge.
    task automatic cyc(input logic s, input logic v, input logic b, input logic j,
                       input logic jr, input logic t, input logic [31:0] tg);
        logic        req;
        logic [31:0] eff;
        stall_i = s; ex_valid_i = v; ex_is_branch_i = b; ex_is_jal_i = j;
        ex_is_jalr_i = jr; branch_taken_i = t; ex_target_i = tg;
        @(posedge clk);
        m_redirect = 1'b0;
        m_mis      = 1'b0;
        if (m_flush_left > 0) begin
            if (!s) begin
                m_pc = m_pc + 32'd4;
                m_flush_left--;
            end
        end else begin
            if (v && b) begin
                m_br++;
                if (t) m_tk++;
            end
            req = v && ((b && t) || j || jr);
            eff = jr ? (tg & 32'hFFFF_FFFE) : tg;
            if (req && (eff % 4 == 0 || eff % 4 == 1)) begin
                m_pc = eff;
                m_flush_left = D;
                m_redirect = 1'b1;
            end else begin
                m_mis = req;
                if (!s) m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic idle(input logic s);
        cyc(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        stall_i = 0; ex_valid_i = 0; ex_is_branch_i = 0; ex_is_jal_i = 0;
        ex_is_jalr_i = 0; branch_taken_i = 0; ex_target_i = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_o); end
        n_checks++; if (pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h want 4", pc_plus4_o); end
        n_checks++; if ({flush_o, redirect_o, misalign_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {flush_o, redirect_o, misalign_o}); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_sequential();
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL seq_start: got %h want 0", pc_o); end
        for (int i = 1; i <= 3; i++) begin
            idle(1'b0);
            n_checks++; if (pc_o !== 32'(4 * i) || flush_o !== 1'b0) begin
                n_fail++; $display("FAIL seq_pc%0d: got pc %h flush %b want pc %h flush 0", i, pc_o, flush_o, 32'(4 * i)); end
        end
    endtask

    task automatic test_taken_branch();
        do_reset();
        for (int i = 0; i < 8; i++) idle(1'b0);
        n_checks++; if (pc_o !== 32'h20) begin n_fail++; $display("FAIL br_pre: got %h want 20", pc_o); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        n_checks++; if (pc_o !== 32'h100 || redirect_o !== 1'b1 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL br_redirect: got pc %h rd %b fl %b want 100 1 1", pc_o, redirect_o, flush_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h104 || redirect_o !== 1'b0 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL br_flush2: got pc %h rd %b fl %b want 104 0 1", pc_o, redirect_o, flush_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h108 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL br_end: got pc %h fl %b want 108 0", pc_o, flush_o); end
        // Back in RUN: a not-taken branch does not redirect.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h800);
        n_checks++; if (pc_o !== 32'h10C || redirect_o !== 1'b0 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL br_not_taken: got pc %h rd %b fl %b want 10c 0 0", pc_o, redirect_o, flush_o); end
    endtask

    task automatic test_jalr_stall();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h201);
        n_checks++; if (pc_o !== 32'h200 || redirect_o !== 1'b1 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL jalr_stall: got pc %h rd %b fl %b want 200 1 1", pc_o, redirect_o, flush_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        n_checks++; if (pc_o !== 32'h204 || redirect_o !== 1'b0 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL jalr_ignore: got pc %h rd %b fl %b want 204 0 1", pc_o, redirect_o, flush_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h208 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL jalr_end: got pc %h fl %b want 208 0", pc_o, flush_o); end
    endtask

    task automatic test_misalign();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102);
        n_checks++; if (pc_o !== 32'h20C || misalign_o !== 1'b1 || redirect_o !== 1'b0 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL mis_pulse: got pc %h mis %b rd %b fl %b want 20c 1 0 0", pc_o, misalign_o, redirect_o, flush_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h210 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL mis_clear: got pc %h mis %b want 210 0", pc_o, misalign_o); end
        // JALR target 0x203 becomes 0x202: still misaligned, and the stall holds the PC.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h203);
        n_checks++; if (pc_o !== 32'h210 || misalign_o !== 1'b1 || redirect_o !== 1'b0) begin
            n_fail++; $display("FAIL mis_jalr_stall: got pc %h mis %b rd %b want 210 1 0", pc_o, misalign_o, redirect_o); end
    endtask

    task automatic test_flush_stall_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
        n_checks++; if (pc_o !== 32'h300 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL fs_redirect: got pc %h fl %b want 300 1", pc_o, flush_o); end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            n_checks++; if (pc_o !== 32'h300 || flush_o !== 1'b1) begin
                n_fail++; $display("FAIL fs_stall%0d: got pc %h fl %b want 300 1", i, pc_o, flush_o); end
        end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h304 || flush_o !== 1'b1) begin
            n_fail++; $display("FAIL fs_run1: got pc %h fl %b want 304 1", pc_o, flush_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h308 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL fs_run2: got pc %h fl %b want 308 0", pc_o, flush_o); end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500);
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc_o !== 32'h0 || flush_o !== 1'b0 || redirect_o !== 1'b0) begin
            n_fail++; $display("FAIL fs_reset: got pc %h fl %b rd %b want 0 0 0", pc_o, flush_o, redirect_o); end
        do_reset();
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h4 || flush_o !== 1'b0) begin
            n_fail++; $display("FAIL fs_after_reset: got pc %h fl %b want 4 0", pc_o, flush_o); end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        n_checks++; if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc4: got pc %h pc4 %h want fffffffc 0", pc_o, pc_plus4_o); end
        idle(1'b0);
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc_o); end
        idle(1'b0);
    endtask

    task automatic test_random();
        logic [31:0] tg;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tg = tg | 32'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, tg);
            n_checks++;
            if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || flush_o !== (m_flush_left > 0) ||
                redirect_o !== m_redirect || misalign_o !== m_mis) begin
                n_fail++;
                $display("FAIL rand_%0d: got pc %h pc4 %h fl %b rd %b mis %b want pc %h fl %b rd %b mis %b",
                         i, pc_o, pc_plus4_o, flush_o, redirect_o, misalign_o,
                         m_pc, (m_flush_left > 0), m_redirect, m_mis);
            end
            n_checks++; if ((redirect_o & misalign_o) !== 1'b0 || (flush_o === 1'b0 && redirect_o === 1'b1)) begin
                n_fail++; $display("FAIL rand_excl_%0d: got rd %b mis %b fl %b", i, redirect_o, misalign_o, flush_o); end
`ifdef BRANCH_PERF_CNT_EN
            n_checks++; if (branch_cnt_o !== m_br || taken_cnt_o !== m_tk) begin
                n_fail++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, branch_cnt_o, taken_cnt_o, m_br, m_tk); end
`endif
        end
    endtask

`ifdef BRANCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        // Branches arriving during the flush window are not counted.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
        n_checks++; if (branch_cnt_o !== 32'd3 || taken_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL perf_cnt: got %0d/%0d want 3/2", branch_cnt_o, taken_cnt_o); end
        idle(1'b0); idle(1'b0);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_taken_branch();
        test_jalr_stall();
        test_misalign();
        test_flush_stall_reset();
        test_wrap();
`ifdef BRANCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
